pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 131 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: load-use interlock, multi-cycle mult/div sequencing, redirect flush.
// Define PIPE_STALL_COUNTER_EN to add the 32-bit stallCycles performance counter output.
module pipeline_ctrl #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] idRs,
  input  logic [4:0] idRt,
  input  logic       idUsesRs,
  input  logic       idUsesRt,
  input  logic       exMemRead,
  input  logic [4:0] exWriteReg,
  input  logic       exBranchTaken,
  input  logic       idMulDivStart,
  input  logic       idIsDiv,
  input  logic       idReadsHiLo,
  output logic       pcWriteEn,
  output logic       ifidWriteEn,
  output logic       ifidFlush,
  output logic       idexFlush,
  output logic       mdBusy,
  output logic       mdDone
`ifdef PIPE_STALL_COUNTER_EN
  ,
  output logic [31:0] stallCycles
`endif
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} md_state_e;

  md_state_e  r_state;
  md_state_e  w_state_next;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_next;
  logic [7:0] w_lat_m1;
  logic       w_load_use;
  logic       w_md_stall;
  logic       w_stall;
  logic       w_accept;

  assign w_load_use = exMemRead & (exWriteReg != 5'd0) &
                      ((idUsesRs & (idRs == exWriteReg)) | (idUsesRt & (idRt == exWriteReg)));

  assign w_md_stall = (r_state == StBusy) & (idReadsHiLo | idMulDivStart);
  assign w_stall    = w_load_use | w_md_stall;
  // Starts are only taken from IDLE or DONE; a redirect squashes the ID instruction.
  assign w_accept   = idMulDivStart & ~w_load_use & ~exBranchTaken;
  assign w_lat_m1   = idIsDiv ? 8'(DIV_LAT - 1) : 8'(MUL_LAT - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_next = StBusy;
          w_cnt_next   = w_lat_m1;
        end
      end
      StBusy: begin
        if (r_cnt == 8'd0) begin
          w_state_next = StDone;
        end else begin
          w_cnt_next = r_cnt - 8'd1;
        end
      end
      StDone: begin
        if (w_accept) begin
          w_state_next = StBusy;
          w_cnt_next   = w_lat_m1;
        end else begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_comb begin
    pcWriteEn   = ~w_stall;
    ifidWriteEn = ~w_stall;
    ifidFlush   = 1'b0;
    idexFlush   = w_stall;
    mdBusy      = (r_state == StBusy);
    mdDone      = (r_state == StDone);
    if (reset) begin
      pcWriteEn   = 1'b0;
      ifidWriteEn = 1'b0;
      ifidFlush   = 1'b1;
      idexFlush   = 1'b1;
      mdBusy      = 1'b0;
      mdDone      = 1'b0;
    end else if (exBranchTaken) begin
      pcWriteEn   = 1'b1;
      ifidWriteEn = 1'b1;
      ifidFlush   = 1'b1;
      idexFlush   = 1'b1;
    end
  end

`ifdef PIPE_STALL_COUNTER_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= 32'd0;
    end else if (w_stall & ~exBranchTaken) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stallCycles = r_stall_cycles;
`else
  // Counter not built: no stallCycles port or register.
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus a randomized run
// against a cycle-timestamp reference model.
module tb_pipeline_ctrl;

  localparam int MulLat = 4;
  localparam int DivLat = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] idRs, idRt, exWriteReg;
  logic       idUsesRs, idUsesRt, exMemRead, exBranchTaken;
  logic       idMulDivStart, idIsDiv, idReadsHiLo;
  logic       pcWriteEn, ifidWriteEn, ifidFlush, idexFlush, mdBusy, mdDone;
`ifdef PIPE_STALL_COUNTER_EN
  logic [31:0] stallCycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .MUL_LAT(MulLat),
    .DIV_LAT(DivLat)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .idRs         (idRs),
    .idRt         (idRt),
    .idUsesRs     (idUsesRs),
    .idUsesRt     (idUsesRt),
    .exMemRead    (exMemRead),
    .exWriteReg   (exWriteReg),
    .exBranchTaken(exBranchTaken),
    .idMulDivStart(idMulDivStart),
    .idIsDiv      (idIsDiv),
    .idReadsHiLo  (idReadsHiLo),
    .pcWriteEn    (pcWriteEn),
    .ifidWriteEn  (ifidWriteEn),
    .ifidFlush    (ifidFlush),
    .idexFlush    (idexFlush),
    .mdBusy       (mdBusy),
    .mdDone       (mdDone)
`ifdef PIPE_STALL_COUNTER_EN
    ,
    .stallCycles  (stallCycles)
`endif
  );

  task automatic quiet();
    idRs = 5'd0; idRt = 5'd0; exWriteReg = 5'd0;
    idUsesRs = 1'b0; idUsesRt = 1'b0; exMemRead = 1'b0; exBranchTaken = 1'b0;
    idMulDivStart = 1'b0; idIsDiv = 1'b0; idReadsHiLo = 1'b0;
  endtask

  // Advance one cycle; inputs are then driven 1ns after the edge, outputs sampled 2ns after.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    quiet();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idRs = 5'd8; idUsesRs = 1'b1; exMemRead = 1'b1; exWriteReg = 5'd8;
    exBranchTaken = 1'b1; idMulDivStart = 1'b1; idReadsHiLo = 1'b1;
    tick();
    #1;
    checks++;
    if ({pcWriteEn, ifidWriteEn, ifidFlush, idexFlush, mdBusy, mdDone} !== 6'b001100) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 001100",
               {pcWriteEn, ifidWriteEn, ifidFlush, idexFlush, mdBusy, mdDone});
    end
    quiet();
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({pcWriteEn, ifidWriteEn, ifidFlush, idexFlush, mdBusy, mdDone} !== 6'b110000) begin
      errors++;
      $display("FAIL reset_release: got %b expected 110000",
               {pcWriteEn, ifidWriteEn, ifidFlush, idexFlush, mdBusy, mdDone});
    end
  endtask

  task automatic test_load_use();
    do_reset();
    exMemRead = 1'b1; exWriteReg = 5'd8; idRs = 5'd8; idUsesRs = 1'b1;
    #1;
    checks++;
    if ({pcWriteEn, ifidWriteEn, idexFlush, ifidFlush} !== 4'b0010) begin
      errors++;
      $display("FAIL load_use_rs: got %b expected 0010",
               {pcWriteEn, ifidWriteEn, idexFlush, ifidFlush});
    end
    tick();
    exMemRead = 1'b0;
    #1;
    checks++;
    if ({pcWriteEn, idexFlush} !== 2'b10) begin
      errors++;
      $display("FAIL load_use_one_cycle: got %b expected 10", {pcWriteEn, idexFlush});
    end
    tick();
    exMemRead = 1'b1; exWriteReg = 5'd0; idRs = 5'd0;
    #1;
    checks++;
    if ({pcWriteEn, idexFlush} !== 2'b10) begin
      errors++;
      $display("FAIL load_use_r0: got %b expected 10", {pcWriteEn, idexFlush});
    end
    tick();
    exWriteReg = 5'd5; idRs = 5'd5; idUsesRs = 1'b0; idRt = 5'd5; idUsesRt = 1'b1;
    #1;
    checks++;
    if ({pcWriteEn, idexFlush} !== 2'b01) begin
      errors++;
      $display("FAIL load_use_rt: got %b expected 01", {pcWriteEn, idexFlush});
    end
    tick();
    idUsesRt = 1'b0;
    #1;
    checks++;
    if ({pcWriteEn, idexFlush} !== 2'b10) begin
      errors++;
      $display("FAIL load_use_unused: got %b expected 10", {pcWriteEn, idexFlush});
    end
    quiet();
  endtask

  task automatic test_multiply();
    do_reset();
    idMulDivStart = 1'b1;
    #1;
    checks++;
    if ({mdBusy, mdDone, pcWriteEn} !== 3'b001) begin
      errors++;
      $display("FAIL mul_cycle0: got %b expected 001", {mdBusy, mdDone, pcWriteEn});
    end
    tick();
    idMulDivStart = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      logic [1:0] exp;
      #1;
      exp = (c <= MulLat) ? 2'b10 : (c == MulLat + 1) ? 2'b01 : 2'b00;
      checks++;
      if ({mdBusy, mdDone} !== exp) begin
        errors++;
        $display("FAIL mul_cycle%0d: busy/done got %b expected %b", c, {mdBusy, mdDone}, exp);
      end
      tick();
    end
  endtask

  task automatic test_divide_mfhi();
    int stalls = 0;
    do_reset();
    idMulDivStart = 1'b1; idIsDiv = 1'b1;
    tick();
    idMulDivStart = 1'b0; idIsDiv = 1'b0; idReadsHiLo = 1'b1;
    for (int c = 1; c <= DivLat; c++) begin
      #1;
      if (!pcWriteEn && idexFlush && mdBusy) stalls++;
      tick();
    end
    checks++;
    if (stalls !== DivLat) begin
      errors++;
      $display("FAIL div_stall_cycles: got %0d expected %0d", stalls, DivLat);
    end
    #1;
    checks++;
    if ({pcWriteEn, idexFlush, mdDone, mdBusy} !== 4'b1010) begin
      errors++;
      $display("FAIL div_release_done: got %b expected 1010",
               {pcWriteEn, idexFlush, mdDone, mdBusy});
    end
    quiet();
  endtask

  task automatic test_branch_override();
    do_reset();
    exMemRead = 1'b1; exWriteReg = 5'd8; idRs = 5'd8; idUsesRs = 1'b1;
    exBranchTaken = 1'b1; idMulDivStart = 1'b1;
    #1;
    checks++;
    if ({pcWriteEn, ifidWriteEn, ifidFlush, idexFlush} !== 4'b1111) begin
      errors++;
      $display("FAIL branch_override: got %b expected 1111",
               {pcWriteEn, ifidWriteEn, ifidFlush, idexFlush});
    end
    tick();
    quiet();
    #1;
    checks++;
    if (mdBusy !== 1'b0) begin
      errors++;
      $display("FAIL branch_start_ignored: mdBusy got %b expected 0", mdBusy);
    end
    // A branch arriving during an issued operation does not cancel it.
    idMulDivStart = 1'b1;
    tick();
    idMulDivStart = 1'b0; exBranchTaken = 1'b1;
    tick();
    exBranchTaken = 1'b0;
    #1;
    checks++;
    if (mdBusy !== 1'b1) begin
      errors++;
      $display("FAIL branch_no_cancel: mdBusy got %b expected 1", mdBusy);
    end
    quiet();
  endtask

  task automatic test_back_to_back();
    do_reset();
    idMulDivStart = 1'b1;
    tick();
    for (int c = 1; c <= MulLat; c++) begin
      #1;
      checks++;
      if ({pcWriteEn, idexFlush, mdBusy} !== 3'b011) begin
        errors++;
        $display("FAIL b2b_stall_c%0d: got %b expected 011", c, {pcWriteEn, idexFlush, mdBusy});
      end
      tick();
    end
    #1;
    checks++;
    if ({pcWriteEn, mdDone} !== 2'b11) begin
      errors++;
      $display("FAIL b2b_accept_done: got %b expected 11", {pcWriteEn, mdDone});
    end
    tick();
    idMulDivStart = 1'b0;
    #1;
    checks++;
    if ({mdBusy, mdDone} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_rebusy: got %b expected 10", {mdBusy, mdDone});
    end
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({pcWriteEn, ifidFlush, mdBusy} !== 3'b010) begin
      errors++;
      $display("FAIL reset_mid_busy: got %b expected 010", {pcWriteEn, ifidFlush, mdBusy});
    end
    tick();
    reset = 1'b0;
    begin
      int seen = 0;
      for (int c = 0; c < MulLat + 4; c++) begin
        #1;
        if (mdDone || mdBusy) seen++;
        tick();
      end
      checks++;
      if (seen !== 0) begin
        errors++;
        $display("FAIL abort_no_done: busy/done cycles got %0d expected 0", seen);
      end
    end
  endtask

`ifdef PIPE_STALL_COUNTER_EN
  task automatic test_stall_counter();
    do_reset();
    exMemRead = 1'b1; exWriteReg = 5'd3; idRt = 5'd3; idUsesRt = 1'b1;
    tick(); tick(); tick();
    exBranchTaken = 1'b1;
    tick();
    quiet();
    #1;
    checks++;
    if (stallCycles !== 32'd3) begin
      errors++;
      $display("FAIL stall_count: got %0d expected 3", stallCycles);
    end
    dut.r_stall_cycles = 32'hFFFF_FFFF;
    exMemRead = 1'b1; exWriteReg = 5'd3; idRt = 5'd3; idUsesRt = 1'b1;
    tick();
    quiet();
    #1;
    checks++;
    if (stallCycles !== 32'd0) begin
      errors++;
      $display("FAIL stall_count_wrap: got %h expected 0", stallCycles);
    end
  endtask
`endif

  // Reference model: an accepted operation at cycle s is busy for cycles s+1..s+lat
  // and reports done at s+lat+1.
  task automatic test_random();
    bit      act = 1'b0;
    longint  s = 0;
    int      lat = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit lu, busy, done, stall;
      logic [5:0] exp, got;
      reset         = ($urandom_range(0, 59) == 0);
      idRs          = 5'($urandom_range(0, 3));
      idRt          = 5'($urandom_range(0, 3));
      exWriteReg    = 5'($urandom_range(0, 3));
      idUsesRs      = 1'($urandom_range(0, 1));
      idUsesRt      = 1'($urandom_range(0, 1));
      exMemRead     = ($urandom_range(0, 2) == 0);
      exBranchTaken = ($urandom_range(0, 7) == 0);
      idMulDivStart = ($urandom_range(0, 3) == 0);
      idIsDiv       = ($urandom_range(0, 4) == 0);
      idReadsHiLo   = ($urandom_range(0, 3) == 0);
      #1;
      lu = exMemRead && exWriteReg != 0 &&
           ((idUsesRs && idRs == exWriteReg) || (idUsesRt && idRt == exWriteReg));
      busy  = act && i > s && i <= s + lat;
      done  = act && i == s + lat + 1;
      stall = lu || (busy && (idReadsHiLo || idMulDivStart));
      if (reset)              exp = 6'b001100;
      else if (exBranchTaken) exp = {4'b1111, busy, done};
      else                    exp = {!stall, !stall, 1'b0, stall, busy, done};
      got = {pcWriteEn, ifidWriteEn, ifidFlush, idexFlush, mdBusy, mdDone};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_cycle%0d: got %b expected %b", i, got, exp);
      end
      if (reset) begin
        act = 1'b0;
      end else if (idMulDivStart && !exBranchTaken && !lu && !busy) begin
        act = 1'b1;
        s   = i;
        lat = idIsDiv ? DivLat : MulLat;
      end
      tick();
    end
    quiet();
    reset = 1'b0;
  endtask

  initial begin
    quiet();
    reset = 1'b1;
    #1;
    test_reset();
    test_load_use();
    test_multiply();
    test_divide_mfhi();
    test_branch_override();
    test_back_to_back();
`ifdef PIPE_STALL_COUNTER_EN
    test_stall_counter();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
